// File: rtl/serial_byte_tx.sv
// Framed LSB-first byte transmitter (start, 8 data, optional odd parity, stop); start bit the cycle after acceptance.
// ready only in IDLE; valid while busy is ignored, not queued; frame length (10+PARITY_EN)*CLKS_PER_BIT cycles.
module serial_byte_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] d,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       txd_q, txd_d;
    logic       bit_end;

    assign bit_end = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_START;
                    shift_d = d;
                    par_d   = ~^d;
                    cnt_d   = 8'd0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    // the shift register always presents the current data bit at [0]
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // txd is registered, so it is derived from the state being entered
    always_comb begin
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    assign txd   = txd_q;
    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Bench for serial_byte_tx: instance a (1 clk/bit, parity) and instance b (4 clk/bit, no parity).
// Stimulus pushes expected waveforms; a negedge monitor captures each frame and compares.
module tb_serial_byte_tx;

    localparam int CPB_A = 1;
    localparam int PAR_A = 1;
    localparam int CPB_B = 4;
    localparam int PAR_B = 0;
    localparam int LEN_A = (10 + PAR_A) * CPB_A;
    localparam int LEN_B = (10 + PAR_B) * CPB_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] d_a, d_b;
    logic       valid_a, valid_b;
    logic       ready_a, txd_a, busy_a, done_a;
    logic       ready_b, txd_b, busy_b, done_b;

    serial_byte_tx #(.CLKS_PER_BIT(CPB_A), .PARITY_EN(PAR_A)) dut_a (
        .clk(clk), .reset(reset), .d(d_a), .valid(valid_a),
        .ready(ready_a), .txd(txd_a), .busy(busy_a), .done(done_a)
    );

    serial_byte_tx #(.CLKS_PER_BIT(CPB_B), .PARITY_EN(PAR_B)) dut_b (
        .clk(clk), .reset(reset), .d(d_b), .valid(valid_b),
        .ready(ready_b), .txd(txd_b), .busy(busy_b), .done(done_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [63:0] wave;
        int          start;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // seq lists the frame bits in transmit order, leftmost bit first on the line
    function automatic logic [63:0] expand(input logic [10:0] seq, input int nbits, input int cpb);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < nbits; i++)
            for (int c = 0; c < cpb; c++)
                w[i*cpb + c] = seq[nbits-1-i];
        return w;
    endfunction

    // ---------------- monitor ----------------
    wire [1:0] txd_w   = {txd_b, txd_a};
    wire [1:0] ready_w = {ready_b, ready_a};
    wire [1:0] busy_w  = {busy_b, busy_a};
    wire [1:0] done_w  = {done_b, done_a};

    logic        cap [2];
    int          pos [2];
    int          st  [2];
    logic [63:0] wv  [2];
    logic [63:0] dm  [2];
    logic [63:0] bm  [2];
    int          mlen;
    exp_t        me;
    logic        got;

    initial begin
        cap[0] = 1'b0;
        cap[1] = 1'b0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mlen = (k == 0) ? LEN_A : LEN_B;
            if (reset === 1'b1) begin
                cap[k] = 1'b0;
            end else if (!cap[k] && txd_w[k] !== 1'b0) begin
                check($sformatf("idle_outputs%0d", k),
                      {60'd0, txd_w[k], ready_w[k], busy_w[k], done_w[k]}, 64'hC);
            end else begin
                if (!cap[k]) begin
                    cap[k] = 1'b1;
                    pos[k] = 0;
                    st[k]  = cyc;
                    wv[k]  = '0;
                    dm[k]  = '0;
                    bm[k]  = '0;
                end
                wv[k][pos[k]] = txd_w[k];
                dm[k][pos[k]] = done_w[k];
                bm[k][pos[k]] = busy_w[k] & ~ready_w[k];
                pos[k]++;
                if (pos[k] == mlen) begin
                    cap[k] = 1'b0;
                    got    = 1'b0;
                    if (k == 0 && q_a.size() > 0) begin me = q_a.pop_front(); got = 1'b1; end
                    if (k == 1 && q_b.size() > 0) begin me = q_b.pop_front(); got = 1'b1; end
                    if (!got) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_frame%0d: frame started at cycle %0d, none expected", k, st[k]);
                    end else begin
                        check($sformatf("frame_txd%0d", k), wv[k], me.wave);
                        check($sformatf("frame_done%0d", k), dm[k], 64'd1 << (mlen - 1));
                        check($sformatf("frame_busy%0d", k), bm[k], (64'd1 << mlen) - 64'd1);
                        check($sformatf("frame_start%0d", k), 64'(st[k]), 64'(me.start));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input int k, input logic [10:0] seq, input int start);
        exp_t e;
        if (k == 0) e.wave = expand(seq, 10 + PAR_A, CPB_A);
        else        e.wave = expand(seq, 10 + PAR_B, CPB_B);
        e.start = start;
        if (k == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // one-cycle valid pulse; d is scrambled right after acceptance
    task automatic send(input int k, input logic [7:0] b, input logic [10:0] seq,
                        input bit expect_frame, output int acc);
        @(posedge clk); #1;
        if (k == 0) begin d_a = b; valid_a = 1'b1; end
        else        begin d_b = b; valid_b = 1'b1; end
        @(posedge clk); #1;
        acc = cyc;
        if (k == 0) begin d_a = ~b; valid_a = 1'b0; end
        else        begin d_b = ~b; valid_b = 1'b0; end
        if (expect_frame) push_exp(k, seq, acc);
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int acc;
    int acc1;

    initial begin
        reset   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        d_a     = 8'h00;
        d_b     = 8'h00;

        // reset held two cycles with valid low
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("reset_state_a", {60'd0, txd_a, ready_a, busy_a, done_a}, 64'hC);
            check("reset_state_b", {60'd0, txd_b, ready_b, busy_b, done_b}, 64'hC);
        end
        reset = 1'b0;
        idle_wait(2);

        // single frame 0x34: start, 00101100, parity 0, stop
        send(0, 8'h34, 11'b0_00101100_0_1, 1'b1, acc);
        idle_wait(LEN_A + 2);

        // back-to-back with valid held: 0xFF then 0x00, one idle cycle between
        @(posedge clk); #1;
        d_a = 8'hFF; valid_a = 1'b1;
        @(posedge clk); #1;
        acc1 = cyc;
        push_exp(0, 11'b0_11111111_1_1, acc1);
        d_a = 8'h00;
        idle_wait(LEN_A + 1);
        push_exp(0, 11'b0_00000000_1_1, acc1 + LEN_A + 1);
        d_a = 8'h5A; valid_a = 1'b0;
        idle_wait(LEN_A + 3);

        // oversampled instance: 0xA5 and 0x3C, no parity
        send(1, 8'hA5, 11'b0_0_10100101_1, 1'b1, acc);
        idle_wait(LEN_B + 2);
        send(1, 8'h3C, 11'b0_0_00111100_1, 1'b1, acc);
        idle_wait(LEN_B + 2);

        // reset during data bit 3 of 0x34; frame abandoned
        send(0, 8'h34, 11'b0_00101100_0_1, 1'b0, acc);
        idle_wait(4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_midframe_a", {60'd0, txd_a, ready_a, busy_a, done_a}, 64'hC);
        idle_wait(1);
        send(0, 8'h01, 11'b0_10000000_0_1, 1'b1, acc);
        idle_wait(LEN_A + 2);

        // valid pulse while busy must be dropped
        send(0, 8'h0F, 11'b0_11110000_1_1, 1'b1, acc);
        idle_wait(2);
        d_a = 8'h55; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        idle_wait(LEN_A + 10);

        check("queue_a_drained", 64'(q_a.size()), 64'd0);
        check("queue_b_drained", 64'(q_b.size()), 64'd0);
        check("monitor_idle", {62'd0, cap[1], cap[0]}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
